pipe_ctrl: RTL and testbench

//  Central pipeline controller for the 6-stage MIPS core (PC, IF, ID, EX, MEM, WB).

---
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 6-stage core.
// Turns the per-stage stall requests into one stall vector and issues the
// exception/ERET flush with its redirect PC. After a flush that lands while
// a fetch is still outstanding, it drains that fetch. It also keeps a stall
// watchdog and two performance counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        exc_valid,
  input  logic        exc_is_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flush_count
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(STALL_TIMEOUT);

  // Stall patterns: each one holds its stage and every stage before it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_TO_ID  = 6'b000111;
  localparam logic [5:0] STALL_TO_EX  = 6'b001111;
  localparam logic [5:0] STALL_TO_MEM = 6'b011111;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               stall_timeout_q, stall_timeout_d;
  logic [31:0]        perf_stall_cycles_q, perf_stall_cycles_d;
  logic [15:0]        perf_flush_count_q, perf_flush_count_d;

  // Stall/flush/redirect decode and FSM next state.
  always_comb begin
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = 32'h0000_0000;
    state_d = state_q;
    if (rst) begin
      // Outputs are forced quiet while reset is held.
      stall   = STALL_NONE;
      flush   = 1'b0;
      new_pc  = 32'h0000_0000;
      state_d = ST_RUN;
    end else if (exc_valid) begin
      // An exception or ERET wins over every stall request, in either state.
      stall   = STALL_NONE;
      flush   = 1'b1;
      new_pc  = exc_is_eret ? cp0_epc : EXC_VECTOR;
      state_d = stallreq_from_if ? ST_DRAIN : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          state_d = ST_RUN;
          if (stallreq_from_mem) begin
            stall = STALL_TO_MEM;
          end else if (stallreq_from_ex) begin
            stall = STALL_TO_EX;
          end else if (stallreq_from_id || stallreq_from_if) begin
            stall = STALL_TO_ID;
          end else begin
            stall = STALL_NONE;
          end
        end
        ST_DRAIN: begin
          // The pipeline is empty, so only the stale fetch matters. The cycle
          // it completes is still a bubble so the stale word never reaches IF/ID.
          stall   = STALL_TO_ID;
          state_d = stallreq_from_if ? ST_DRAIN : ST_RUN;
        end
        default: begin
          stall   = STALL_NONE;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Watchdog and performance counter next-state values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall[0] && !flush) begin
      stall_cnt_d = (stall_cnt_q == TIMEOUT_C) ? TIMEOUT_C : stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = {CNT_W{1'b0}};
    end
    stall_timeout_d     = stall_timeout_q | (stall_cnt_d == TIMEOUT_C);
    perf_stall_cycles_d = perf_stall_cycles_q + {31'd0, stall[0]};
    perf_flush_count_d  = perf_flush_count_q + {15'd0, flush};
  end

  // State, watchdog and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= ST_RUN;
      stall_cnt_q         <= {CNT_W{1'b0}};
      stall_timeout_q     <= 1'b0;
      perf_stall_cycles_q <= 32'h0000_0000;
      perf_flush_count_q  <= 16'h0000;
    end else begin
      state_q             <= state_d;
      stall_cnt_q         <= stall_cnt_d;
      stall_timeout_q     <= stall_timeout_d;
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_flush_count_q  <= perf_flush_count_d;
    end
  end

  assign stall_timeout     = stall_timeout_q;
  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_flush_count  = perf_flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a rule-level model is compared against
// the DUT every cycle, and hand-computed literals are checked at key points.
module tb_pipe_ctrl;

  localparam int T_OUT = 8;

  logic        clk;
  logic        rst;
  logic        if_r, id_r, ex_r, mem_r;
  logic        exc, eret;
  logic [31:0] epc;
  logic [5:0]  stall_s;
  logic        flush_s;
  logic [31:0] new_pc_s;
  logic        timeout_s;
  logic [31:0] pstall_s;
  logic [15:0] pflush_s;

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .STALL_TIMEOUT(T_OUT),
    .CNT_W        (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (if_r),
    .stallreq_from_id (id_r),
    .stallreq_from_ex (ex_r),
    .stallreq_from_mem(mem_r),
    .exc_valid        (exc),
    .exc_is_eret      (eret),
    .cp0_epc          (epc),
    .stall            (stall_s),
    .flush            (flush_s),
    .new_pc           (new_pc_s),
    .stall_timeout    (timeout_s),
    .perf_stall_cycles(pstall_s),
    .perf_flush_count (pflush_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Model state: "a stale fetch is being drained", watchdog run length, counters.
  bit          m_drain;
  int          m_run;
  bit          m_to;
  logic [31:0] m_ps;
  logic [15:0] m_pf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample at the falling edge: compare against the model, then advance the model.
  task automatic sample();
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    @(negedge clk);
    es = 6'b000000; ef = 1'b0; ep = 32'h0;
    if (rst) begin
      es = 6'b000000;
    end else if (exc) begin
      ef = 1'b1;
      ep = eret ? epc : 32'h0000_0020;
    end else if (m_drain) begin
      es = 6'b000111;
    end else if (mem_r) begin
      es = 6'b011111;
    end else if (ex_r) begin
      es = 6'b001111;
    end else if (id_r || if_r) begin
      es = 6'b000111;
    end
    chk("stall", {26'd0, stall_s}, {26'd0, es});
    chk("flush", {31'd0, flush_s}, {31'd0, ef});
    chk("new_pc", new_pc_s, ep);
    chk("stall_timeout", {31'd0, timeout_s}, {31'd0, m_to});
    chk("perf_stall_cycles", pstall_s, m_ps);
    chk("perf_flush_count", {16'd0, pflush_s}, {16'd0, m_pf});
    if (rst) begin
      m_drain = 1'b0; m_run = 0; m_to = 1'b0; m_ps = 32'h0; m_pf = 16'h0;
    end else begin
      m_drain = (exc || m_drain) && if_r;
      if (es[0]) m_run = (m_run >= T_OUT) ? T_OUT : m_run + 1;
      else m_run = 0;
      if (m_run == T_OUT) m_to = 1'b1;
      m_ps = m_ps + {31'd0, es[0]};
      m_pf = m_pf + {15'd0, ef};
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic reqs(input logic i, input logic d, input logic e, input logic m);
    if_r = i; id_r = d; ex_r = e; mem_r = m;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_drain = 1'b0; m_run = 0; m_to = 1'b0; m_ps = 32'h0; m_pf = 16'h0;
    rst = 1'b1; exc = 1'b0; eret = 1'b0; epc = 32'h0;
    reqs(1'b1, 1'b1, 1'b1, 1'b1);

    // 1 Reset with every request high.
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("rst_stall", {26'd0, stall_s}, 32'h0);
      chk("rst_flush", {31'd0, flush_s}, 32'h0);
      adv();
    end
    chk("rst_perf_stall", pstall_s, 32'h0);
    chk("rst_perf_flush", {16'd0, pflush_s}, 32'h0);
    rst = 1'b0;
    sample();
    chk("release_stall", {26'd0, stall_s}, 32'h0000_001F);
    adv();

    // 2 Priority after a fresh reset.
    rst = 1'b1; reqs(1'b0, 1'b0, 1'b0, 1'b0); cyc(); rst = 1'b0;
    reqs(1'b0, 1'b1, 1'b1, 1'b1); sample();
    chk("prio_mem", {26'd0, stall_s}, 32'h0000_001F); adv();
    reqs(1'b0, 1'b1, 1'b1, 1'b0); sample();
    chk("prio_ex", {26'd0, stall_s}, 32'h0000_000F); adv();
    reqs(1'b0, 1'b1, 1'b0, 1'b0); sample();
    chk("prio_id", {26'd0, stall_s}, 32'h0000_0007); adv();
    reqs(1'b1, 1'b0, 1'b0, 1'b0); sample();
    chk("prio_if", {26'd0, stall_s}, 32'h0000_0007); adv();
    reqs(1'b0, 1'b0, 1'b0, 1'b0); sample();
    chk("perf_stall_4", pstall_s, 32'd4); adv();

    // 3 ERET beats a mem stall.
    exc = 1'b1; eret = 1'b1; epc = 32'hBFC0_0100; reqs(1'b0, 1'b0, 1'b0, 1'b1);
    sample();
    chk("eret_flush", {31'd0, flush_s}, 32'd1);
    chk("eret_stall", {26'd0, stall_s}, 32'h0);
    chk("eret_pc", new_pc_s, 32'hBFC0_0100);
    adv();
    exc = 1'b0; eret = 1'b0; reqs(1'b0, 1'b0, 1'b0, 1'b0); sample();
    chk("eret_count", {16'd0, pflush_s}, 32'd1); adv();

    // 4 Exception with a fetch outstanding, then drain.
    exc = 1'b1; reqs(1'b1, 1'b0, 1'b0, 1'b0); sample();
    chk("exc_pc", new_pc_s, 32'h0000_0020); adv();
    exc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      reqs(1'b1, (k >= 1) ? 1'b1 : 1'b0, 1'b0, (k == 3) ? 1'b1 : 1'b0);
      sample();
      chk("drain_stall", {26'd0, stall_s}, 32'h0000_0007);
      chk("drain_flush", {31'd0, flush_s}, 32'd0);
      adv();
    end
    reqs(1'b0, 1'b1, 1'b0, 1'b0); sample();
    chk("drain_bubble", {26'd0, stall_s}, 32'h0000_0007); adv();
    reqs(1'b0, 1'b0, 1'b1, 1'b0); sample();
    chk("back_to_run", {26'd0, stall_s}, 32'h0000_000F); adv();
    // Exception arriving mid-drain, fetch completes that same cycle.
    exc = 1'b1; reqs(1'b1, 1'b0, 1'b0, 1'b0); cyc();
    reqs(1'b1, 1'b0, 1'b0, 1'b1); exc = 1'b0; cyc();
    exc = 1'b1; eret = 1'b1; epc = 32'h8000_1234; reqs(1'b0, 1'b0, 1'b0, 1'b0); sample();
    chk("drain_exc_pc", new_pc_s, 32'h8000_1234); adv();
    exc = 1'b0; eret = 1'b0; reqs(1'b0, 1'b1, 1'b0, 1'b1); sample();
    chk("run_after_drain_exc", {26'd0, stall_s}, 32'h0000_001F); adv();
    reqs(1'b0, 1'b0, 1'b0, 1'b0); cyc();

    // 5 Watchdog.
    rst = 1'b1; cyc(); rst = 1'b0;
    reqs(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < T_OUT; k++) begin
      sample();
      chk("wd_not_yet", {31'd0, timeout_s}, 32'd0);
      adv();
    end
    reqs(1'b0, 1'b0, 1'b0, 1'b0); sample();
    chk("wd_set", {31'd0, timeout_s}, 32'd1); adv();
    cyc(); cyc();
    sample(); chk("wd_sticky", {31'd0, timeout_s}, 32'd1); adv();
    rst = 1'b1; cyc(); rst = 1'b0;
    sample(); chk("wd_cleared", {31'd0, timeout_s}, 32'd0); adv();
    // A flush breaks a run: 7 + flush + 7 stalls never times out.
    reqs(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) cyc();
    exc = 1'b1; cyc(); exc = 1'b0;
    for (int k = 0; k < 7; k++) cyc();
    reqs(1'b0, 1'b0, 1'b0, 1'b0); sample();
    chk("wd_flush_clears", {31'd0, timeout_s}, 32'd0); adv();

    // 6 Flush counter wrap.
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    force dut.perf_flush_count_q = 16'hFFFF;
    #1;
    release dut.perf_flush_count_q;
    m_pf = 16'hFFFF;
    exc = 1'b1; cyc(); exc = 1'b0;
    sample(); chk("flush_wrap", {16'd0, pflush_s}, 32'h0000_0000); adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
